// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two 1-entry write-back slots sharing one register file write port, round-robin served.
// Define WB_ARB_FWD_EN to enable same-cycle forwarding of held slot data to the read addresses.
module wb_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [31:0]   pending,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic          fwd0_hit,
    output logic [DW-1:0] fwd0_data,
    output logic          fwd1_hit,
    output logic [DW-1:0] fwd1_data
);
    logic          v0_q, v0_d, v1_q, v1_d;
    logic          older0_q, older0_d, older1_q, older1_d;
    logic          lg_q, lg_d;
    logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic          g0, g1, ld0, ld1;

    // Same-address pairs drain oldest first so the register file ends with the youngest value.
    assign g0 = v0_q && (!v1_q || ((addr0_q == addr1_q) ? older0_q : lg_q));
    assign g1 = v1_q && !g0;
    assign req0_ready = !v0_q || g0;
    assign req1_ready = !v1_q || g1;
    assign ld0 = req0_valid && req0_ready && (req0_addr != '0);
    assign ld1 = req1_valid && req1_ready && (req1_addr != '0);

    always_comb begin
        v0_d     = ld0 || (v0_q && !g0);
        v1_d     = ld1 || (v1_q && !g1);
        addr0_d  = ld0 ? req0_addr : addr0_q;
        data0_d  = ld0 ? req0_data : data0_q;
        addr1_d  = ld1 ? req1_addr : addr1_q;
        data1_d  = ld1 ? req1_data : data1_q;
        older0_d = (ld0 && ld1) ? 1'b1 : ld0 ? !v1_d : ld1 ? v0_d : older0_q;
        older1_d = (ld0 && ld1) ? 1'b0 : ld1 ? !v0_d : ld0 ? v1_d : older1_q;
        lg_d     = g1 ? 1'b1 : g0 ? 1'b0 : lg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            older0_q <= 1'b0;
            older1_q <= 1'b0;
            lg_q     <= 1'b1;
            addr0_q  <= '0;
            addr1_q  <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            older0_q <= older0_d;
            older1_q <= older1_d;
            lg_q     <= lg_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
        end
    end

    assign rf_we    = g0 || g1;
    assign rf_waddr = g0 ? addr0_q : g1 ? addr1_q : '0;
    assign rf_wdata = g0 ? data0_q : g1 ? data1_q : '0;

    always_comb begin
        pending = '0;
        if (v0_q) pending[addr0_q] = 1'b1;
        if (v1_q) pending[addr1_q] = 1'b1;
        pending[0] = 1'b0;
    end

`ifdef WB_ARB_FWD_EN
    function automatic logic [DW:0] fwd(input logic [AW-1:0] ra);
        logic h0, h1;
        h0 = v0_q && (ra != '0) && (addr0_q == ra);
        h1 = v1_q && (ra != '0) && (addr1_q == ra);
        return !(h0 || h1) ? '0 : {1'b1, (h0 && h1) ? (older0_q ? data1_q : data0_q) : h1 ? data1_q : data0_q};
    endfunction

    assign {fwd0_hit, fwd0_data} = fwd(raddr0);
    assign {fwd1_hit, fwd1_data} = fwd(raddr1);
`else
    logic unused_raddr;
    assign unused_raddr = ^{raddr0, raddr1};
    assign {fwd0_hit, fwd0_data} = '0;
    assign {fwd1_hit, fwd1_data} = '0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: timestamp-based slot model checked every cycle, plus directed literal checks.
module tb_wb_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 0, rst_n = 0;
    logic          req0_valid = 0, req1_valid = 0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr = 0, req1_addr = 0, raddr0 = 0, raddr1 = 0;
    logic [DW-1:0] req0_data = 0, req1_data = 0;
    logic          rf_we, fwd0_hit, fwd1_hit;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata, fwd0_data, fwd1_data;
    logic [31:0]   pending;

    wb_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending),
        .raddr0(raddr0), .raddr1(raddr1),
        .fwd0_hit(fwd0_hit), .fwd0_data(fwd0_data), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each held write carries its acceptance timestamp; lower timestamp means older.
    bit            mv[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] md[2];
    int            ts[2];
    int            last = 1, cyc = 0;
    logic [DW-1:0] tb_rf[32];
    int            wcount = 0;

    function automatic int grant();
        if (mv[0] && mv[1]) begin
            if (ma[0] != ma[1]) return (last == 0) ? 1 : 0;
            return (ts[0] < ts[1]) ? 0 : 1;
        end
        if (mv[0]) return 0;
        if (mv[1]) return 1;
        return -1;
    endfunction

    function automatic logic [DW:0] model_fwd(input logic [AW-1:0] ra);
`ifdef WB_ARB_FWD_EN
        int best = -1;
        for (int n = 0; n < 2; n++)
            if (mv[n] && ra != 0 && ma[n] == ra) begin
                if (best < 0) best = n;
                else if (ts[n] > ts[best]) best = n;
            end
        if (best < 0) return '0;
        return {1'b1, md[best]};
`else
        return '0;
`endif
    endfunction

    initial forever begin
        @(negedge rst_n);
        mv[0] = 0;
        mv[1] = 0;
        last = 1;
    end

    initial forever begin
        int g;
        bit rd0, rd1;
        @(posedge clk);
        if (rst_n) begin
            g = grant();
            rd0 = !mv[0] || g == 0;
            rd1 = !mv[1] || g == 1;
            if (g >= 0) begin
                mv[g] = 0;
                last = g;
            end
            cyc++;
            if (req0_valid && rd0 && req0_addr != 0) begin
                mv[0] = 1; ma[0] = req0_addr; md[0] = req0_data; ts[0] = 2 * cyc;
            end
            if (req1_valid && rd1 && req1_addr != 0) begin
                mv[1] = 1; ma[1] = req1_addr; md[1] = req1_data; ts[1] = 2 * cyc + 1;
            end
        end
    end

    initial forever begin
        int g;
        logic [31:0] pm;
        logic [DW:0] f0, f1;
        @(negedge clk);
        g = grant();
        pm = 0;
        for (int n = 0; n < 2; n++) if (mv[n]) pm[ma[n]] = 1;
        f0 = model_fwd(raddr0);
        f1 = model_fwd(raddr1);
        chk("rf_we", rf_we, g >= 0);
        chk("rf_waddr", rf_waddr, (g >= 0) ? ma[g >= 0 ? g : 0] : 0);
        chk("rf_wdata", rf_wdata, (g >= 0) ? md[g >= 0 ? g : 0] : 0);
        chk("req0_ready", req0_ready, !mv[0] || g == 0);
        chk("req1_ready", req1_ready, !mv[1] || g == 1);
        chk("pending", pending, pm);
        chk("fwd0", {fwd0_hit, fwd0_data}, f0);
        chk("fwd1", {fwd1_hit, fwd1_data}, f1);
        if (rf_we) begin
            tb_rf[rf_waddr] = rf_wdata;
            wcount++;
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
    endtask

    initial begin
        logic [AW-1:0] seq[4];
        logic          r0[4], r1[4];
        int            snap;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_ready0", req0_ready, 1);
        chk("rst_ready1", req1_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_pending", pending, 0);

        @(posedge clk); #1 req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
        @(negedge clk); chk("t1_ready", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        chk("t1_pending", pending, 32'h20);
        @(negedge clk);
        chk("t1_pending_after", pending, 0);
        chk("t1_we_after", rf_we, 0);

        pulse_reset();
        @(posedge clk); #1 req0_valid = 1; req0_addr = 1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 2; req1_data = 32'h22;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq[i] = rf_waddr; r0[i] = req0_ready; r1[i] = req1_ready;
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", seq[i], (i % 2 == 0) ? 1 : 2);
            chk("t2_ready0", r0[i], i % 2 == 0);
            chk("t2_ready1", r1[i], i % 2 == 1);
        end
        repeat (4) @(negedge clk);

        @(posedge clk); #1 req0_valid = 1; req0_addr = 7; req0_data = 32'hAAAA;
        req1_valid = 1; req1_addr = 7; req1_data = 32'hBBBB;
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        @(negedge clk); chk("t3_first", rf_wdata, 32'hAAAA);
        @(negedge clk); chk("t3_second", rf_wdata, 32'hBBBB);
        @(negedge clk); chk("t3_final_x7", tb_rf[7], 32'hBBBB);

        @(posedge clk); #1 req1_valid = 1; req1_addr = 0; req1_data = 32'h1234;
        @(negedge clk); chk("t4_ready", req1_ready, 1);
        @(posedge clk); #1 req1_valid = 0;
        @(negedge clk);
        chk("t4_we", rf_we, 0);
        chk("t4_pending", pending, 0);

        @(posedge clk); #1 req0_valid = 1; req0_addr = 9; req0_data = 32'h55; raddr0 = 9;
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
`ifdef WB_ARB_FWD_EN
        chk("t5_hit", fwd0_hit, 1);
        chk("t5_data", fwd0_data, 32'h55);
`else
        chk("t5_hit", fwd0_hit, 0);
`endif
        #1 raddr0 = 0;
        #1 chk("t5_hit_x0", fwd0_hit, 0);

        @(posedge clk); #1 req0_valid = 1; req0_addr = 3; req0_data = 32'h33;
        req1_valid = 1; req1_addr = 4; req1_data = 32'h44;
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        @(negedge clk); chk("t6_pending", pending, 32'h18);
        snap = wcount;
        #1 rst_n = 0;
        #1 chk("t6_rst_we", rf_we, 0);
        chk("t6_rst_pending", pending, 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (4) @(negedge clk);
        chk("t6_no_write", wcount, snap);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
